// File: rtl/fetch_if.sv
// Fetch-side bus bundle: the instruction-memory request path and the
// decoupled fetch-buffer output handshake toward decode.
//
//   imem_addr  fetch address          (master -> slave)
//   imem_req   fetch request          (master -> slave)
//   imem_data  instruction word       (slave  -> master, combinational)
//   out_valid  head entry valid       (master -> slave)
//   out_ready  decode accepts head    (slave  -> master)
//   out_pc     head entry PC          (master -> slave)
//   out_inst   head entry instruction (master -> slave)
interface fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic [31:0]     imem_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;

    modport master (
        output imem_addr, imem_req, out_valid, out_pc, out_inst,
        input  imem_data, out_ready
    );

    modport slave (
        input  imem_addr, imem_req, out_valid, out_pc, out_inst,
        output imem_data, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation feeding a small FIFO
// fetch buffer that decode drains through a valid/ready handshake.
// Redirect flushes the buffer and restarts fetch; halt_req stops new fetches
// while the buffer keeps draining.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-low
//   bus          fetch_if.master (imem request path + decode handshake)
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  restart address (low two bits dropped)
//   halt_req     stop issuing fetches
//   count        buffer occupancy
//   misaligned   sticky: a redirect_pc with nonzero bits [1:0] was seen
//
// Optional build macro FETCH_JAL_PREDECODE_EN: when defined, a fetched JAL
// steers the next fetch to its target instead of PC+4.
//
// state  | meaning
// BOOT   | first cycle after reset, no fetch
// RUN    | fetching whenever the buffer has room
// HALTED | no fetch; buffer drains; leaves only on redirect
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    fetch_if.master                bus,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   halt_req,
    output logic [$clog2(DEPTH):0] count,
    output logic                   misaligned
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, pc_seq;
    logic [XLEN-1:0] buf_pc   [DEPTH];
    logic [31:0]     buf_inst [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;

    // Head fields come straight out of buffer storage, never from imem_data.
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = buf_pc[rd_ptr];
    assign bus.out_inst  = buf_inst[rd_ptr];

    // A redirect cycle neither pops nor pushes. A pop frees a slot in the
    // same cycle, so a full buffer can still fetch while decode drains.
    assign pop          = bus.out_valid && bus.out_ready && !redirect;
    assign push         = reset && (state == RUN) && !redirect && ((count < FULL) || pop);
    assign bus.imem_req = push;
    assign bus.imem_addr = pc;

`ifdef FETCH_JAL_PREDECODE_EN
    logic [20:0] j_imm;
    assign j_imm  = {bus.imem_data[31], bus.imem_data[19:12], bus.imem_data[20],
                     bus.imem_data[30:21], 1'b0};
    assign pc_seq = (bus.imem_data[6:0] == 7'b1101111)
                  ? pc + {{(XLEN-21){j_imm[20]}}, j_imm}
                  : pc + XLEN'(4);
`else
    assign pc_seq = pc + XLEN'(4);
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_req && !redirect) state_nxt = HALTED;
            HALTED:  if (redirect) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
        if (redirect)
            pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
        else if (push)
            pc_nxt = pc_seq;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            misaligned <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_inst[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (redirect && (redirect_pc[1:0] != 2'b00))
                misaligned <= 1'b1;
            if (redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    buf_pc[wr_ptr]   <= pc;
                    buf_inst[wr_ptr] <= bus.imem_data;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)
                    count <= count + (PW+1)'(1);
                else if (pop && !push)
                    count <= count - (PW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic.
// A behavioural model tracks fetch PC, occupancy and run/halt status and
// queues every expected buffer entry; a separate monitor pops that queue
// whenever the DUT hands an entry to decode.
module tb_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  count;
    logic        misaligned;

    fetch_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .count       (count),
        .misaligned  (misaligned)
    );

    always #5 clock = ~clock;

    // Instruction memory: address-derived words, with one optional JAL slot.
    logic        jal_en = 1'b0;
    logic [31:0] jal_addr = '0;
    logic [31:0] jal_word = '0;
    assign bus.imem_data = (jal_en && bus.imem_addr == jal_addr) ? jal_word
                         : {bus.imem_addr[24:0] ^ 25'hABCDEF, 7'h13};

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (jal_en && a == jal_addr) return jal_word;
        return {a[24:0] ^ 25'hABCDEF, 7'h13};
    endfunction

    function automatic logic [31:0] next_pc_f(logic [31:0] p, logic [31:0] w);
`ifdef FETCH_JAL_PREDECODE_EN
        logic [20:0] j;
        if (w[6:0] == 7'b1101111) begin
            j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
            return p + {{11{j[20]}}, j};
        end
`endif
        return p + 32'd4;
    endfunction

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        sbq[$];
    bit          m_ready  = 1'b0;
    bit          m_boot   = 1'b1;
    bit          m_halted = 1'b0;
    bit          m_mis    = 1'b0;
    logic [31:0] m_pc     = RESET_PC;
    int          m_cnt    = 0;

    function automatic bit m_fetch();
        return reset && m_ready && !m_boot && !m_halted && !redirect &&
               (m_cnt < DEPTH || (m_cnt != 0 && bus.out_ready));
    endfunction

    always @(posedge clock) begin
        bit          f;
        bit          p;
        logic [31:0] w;
        if (!reset) begin
            m_ready  = 1'b1;
            m_boot   = 1'b1;
            m_halted = 1'b0;
            m_pc     = RESET_PC;
            m_cnt    = 0;
            m_mis    = 1'b0;
            sbq.delete();
        end else if (m_ready) begin
            f = m_fetch();
            p = (m_cnt != 0) && bus.out_ready && !redirect;
            w = mem_word(m_pc);
            if (redirect) begin
                m_cnt = 0;
                sbq.delete();
                if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (f) begin
                    sbq.push_back('{pc: m_pc, inst: w});
                    m_pc = next_pc_f(m_pc, w);
                end
                m_cnt = m_cnt + (f ? 1 : 0) - (p ? 1 : 0);
            end
            if (m_boot)
                m_boot = 1'b0;
            else if (m_halted) begin
                if (redirect) m_halted = 1'b0;
            end else if (halt_req && !redirect)
                m_halted = 1'b1;
        end
    end

    // Fetch-side and occupancy checks against the model
    always @(negedge clock) begin
        bit f;
        if (m_ready) begin
            f = m_fetch();
            check("imem_req", bus.imem_req, f);
            if (f) check("imem_addr", bus.imem_addr, m_pc);
            check("count", count, m_cnt);
            check("out_valid", bus.out_valid, m_cnt != 0);
            check("misaligned", misaligned, m_mis);
        end
    end

    // Output monitor: pops the scoreboard on every accepted head entry
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_inst;
    always @(negedge clock) begin
        ent_t e;
        if (prev_hold) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_pc", bus.out_pc, prev_pc);
            check("hold_inst", bus.out_inst, prev_inst);
        end
        prev_hold = reset && bus.out_valid && !bus.out_ready && !redirect;
        prev_pc   = bus.out_pc;
        prev_inst = bus.out_inst;
        if (reset && m_ready && bus.out_valid && bus.out_ready && !redirect) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: DUT popped pc %0h with no expected entry", bus.out_pc);
            end else begin
                e = sbq.pop_front();
                check("out_pc", bus.out_pc, e.pc);
                check("out_inst", bus.out_inst, e.inst);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_inst", bus.out_inst, 32'h0);
        check("rst_req", bus.imem_req, 1'b0);

        // Release with decode always ready
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("boot_req", bus.imem_req, 1'b0);
        step();
        @(negedge clock);
        check("first_req", bus.imem_req, 1'b1);
        check("first_addr", bus.imem_addr, 32'h0100_0000);
        repeat (10) step();

        // Fill while decode stalls, then one pop+push on a full buffer
        bus.out_ready = 1'b0;
        repeat (8) step();
        @(negedge clock);
        check("full_count", count, 3'd4);
        check("full_req", bus.imem_req, 1'b0);
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clock);
        check("full_pushpop_count", count, 3'd4);

        // Redirect flush
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0100_0100;
        step();
        redirect = 1'b0;
        @(negedge clock);
        check("redir_count", count, 3'd0);
        check("redir_valid", bus.out_valid, 1'b0);
        check("redir_addr", bus.imem_addr, 32'h0100_0100);

        // Misaligned redirect
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0100_0102;
        step();
        redirect = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("mis_addr", bus.imem_addr, 32'h0100_0100);
        check("mis_flag", misaligned, 1'b1);
        repeat (5) step();

        // JAL +16 at 0x01000008
        jal_en = 1'b1;
        jal_addr = 32'h0100_0008;
        jal_word = 32'h0100_006F;
        redirect = 1'b1;
        redirect_pc = 32'h0100_0000;
        step();
        redirect = 1'b0;
        repeat (2) step();
        @(negedge clock);
        check("jal_addr", bus.imem_addr, 32'h0100_0008);
        step();
        @(negedge clock);
`ifdef FETCH_JAL_PREDECODE_EN
        check("jal_next", bus.imem_addr, 32'h0100_0018);
`else
        check("jal_next", bus.imem_addr, 32'h0100_000C);
`endif
        step();
        jal_en = 1'b0;

        // Halt with two entries buffered, then drain
        bus.out_ready = 1'b0;
        step();
        halt_req = 1'b1;
        bus.out_ready = 1'b1;
        step();
        halt_req = 1'b0;
        repeat (5) step();
        @(negedge clock);
        check("halt_req_off", bus.imem_req, 1'b0);
        check("halt_drained", count, 3'd0);
        check("halt_valid", bus.out_valid, 1'b0);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0100_0040;
        step();
        redirect = 1'b0;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            halt_req      = ($urandom_range(0, 31) == 0);
            redirect      = ($urandom_range(0, 19) == 0);
            redirect_pc   = RESET_PC + 32'($urandom_range(0, 255));
            step();
        end
        bus.out_ready = 1'b1;
        halt_req = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0100_0002;
        step();
        redirect = 1'b0;
        repeat (3) step();

        // Reset clears the sticky flag and the buffer
        reset = 1'b0;
        step();
        @(negedge clock);
        check("rst2_mis", misaligned, 1'b0);
        check("rst2_count", count, 3'd0);
        check("rst2_req", bus.imem_req, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
